// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch stage: PC, ROM index, fetch queue, redirects
// Optional IFETCH_MISALIGN_CHK_EN traps misaligned redirects into a sticky error state.
module ifetch_unit #(
    parameter int          XLEN       = 32,
    parameter int          ADDR_WIDTH = 5,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FQ_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [XLEN-1:0]       imem_instr,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic [XLEN-1:0]       dec_instr,
    output logic [XLEN-1:0]       dec_pc,
    output logic                  fetch_err
);
    localparam int PW = $clog2(FQ_DEPTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    logic [1:0]      state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] last_pc;
    logic [XLEN-1:0] q_pc    [FQ_DEPTH];
    logic [XLEN-1:0] q_instr [FQ_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;

    logic            full;
    logic            pop;
    logic            push;
    logic            redirect_take;
    logic            misalign;
    logic [XLEN-1:0] redirect_target;

    assign imem_addr     = pc[ADDR_WIDTH+1:2];
    assign full          = (count == (PW+1)'(FQ_DEPTH));
    assign dec_valid     = (count != '0);
    assign pop           = dec_valid & dec_ready;
    assign redirect_take = redirect_valid && (state != S_ERR);
    assign push          = (state == S_RUN) && !redirect_take && (!full || pop);

    assign dec_instr = dec_valid ? q_instr[rd_ptr] : NOP;
    assign dec_pc    = dec_valid ? q_pc[rd_ptr] : last_pc;

`ifdef IFETCH_MISALIGN_CHK_EN
    logic err_q;
    assign misalign        = redirect_take && (redirect_pc[1:0] != 2'b00);
    assign redirect_target = misalign ? redirect_pc : (redirect_pc & ~XLEN'(3));
    assign fetch_err       = err_q;
`else
    assign misalign        = 1'b0;
    assign redirect_target = redirect_pc & ~XLEN'(3);
    assign fetch_err       = 1'b0;
`endif

    // Queue storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= pc;
            q_instr[wr_ptr] <= imem_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            last_pc <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
`ifdef IFETCH_MISALIGN_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            last_pc <= dec_pc;
            if (redirect_take) begin
                pc     <= redirect_target;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                if (misalign) begin
                    state <= S_ERR;
`ifdef IFETCH_MISALIGN_CHK_EN
                    err_q <= 1'b1;
`endif
                end
            end else begin
                case (state)
                    S_IDLE:  if (fetch_en)  state <= S_RUN;
                    S_RUN:   if (!fetch_en) state <= S_IDLE;
                    default: state <= state;
                endcase
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    pc     <= pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed self-checking bench for ifetch_unit
module tb_ifetch_unit;
    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic [4:0]  imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        fetch_err;

    logic [31:0] rom [32];
    int checks = 0;
    int errors = 0;

    ifetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .fetch_err      (fetch_err)
    );

    assign imem_instr = rom[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        fetch_en       = 1'b0;
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick();
        rst = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    logic [31:0] exp_instr [4];

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'h1000_0000 + i;
        rom[0] = 32'h0000_0193;
        rom[1] = 32'h0010_0213;
        rom[2] = 32'h0020_0293;
        rom[3] = 32'h0050_01B3;
        exp_instr[0] = 32'h0000_0193;
        exp_instr[1] = 32'h0010_0213;
        exp_instr[2] = 32'h0020_0293;
        exp_instr[3] = 32'h0050_01B3;

        // reset state
        do_reset();
        chk("rst_valid", {31'b0, dec_valid}, 32'h0);
        chk("rst_instr", dec_instr, 32'h0000_0013);
        chk("rst_pc", dec_pc, 32'h0);
        chk("rst_err", {31'b0, fetch_err}, 32'h0);
        chk("rst_addr", {27'b0, imem_addr}, 32'h0);

        // streaming at one per cycle, first valid two cycles after enable
        fetch_en  = 1'b1;
        dec_ready = 1'b1;
        tick();
        chk("lat_c1_valid", {31'b0, dec_valid}, 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("strm_valid", {31'b0, dec_valid}, 32'h1);
            chk("strm_pc", dec_pc, 32'(i * 4));
            chk("strm_instr", dec_instr, exp_instr[i]);
            tick();
        end

        // back-pressure: fill, hold pc, then drain without gaps
        do_reset();
        fetch_en = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("full_valid", {31'b0, dec_valid}, 32'h1);
        chk("full_head", dec_pc, 32'h0);
        chk("full_pc_hold", {27'b0, imem_addr}, 32'h2);
        dec_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("drain_pc", dec_pc, 32'(i * 4));
            chk("drain_instr", dec_instr, exp_instr[i]);
        end

        // redirect while queue holds pc 0 and 4
        do_reset();
        fetch_en = 1'b1;
        tick();
        tick();
        tick();
        chk("pre_redir_head", dec_pc, 32'h0);
        dec_ready = 1'b1;
        redirect(32'h0000_000C);
        chk("redir_n1_valid", {31'b0, dec_valid}, 32'h0);
        chk("redir_n1_nop", dec_instr, 32'h0000_0013);
        chk("redir_n1_pchold", dec_pc, 32'h0);
        tick();
        chk("redir_n2_valid", {31'b0, dec_valid}, 32'h1);
        chk("redir_n2_pc", dec_pc, 32'h0000_000C);
        chk("redir_n2_instr", dec_instr, 32'h0050_01B3);

        // redirect in IDLE only moves pc
        do_reset();
        redirect(32'h0000_0010);
        chk("idle_redir_addr", {27'b0, imem_addr}, 32'h4);
        chk("idle_redir_valid", {31'b0, dec_valid}, 32'h0);
        fetch_en  = 1'b1;
        dec_ready = 1'b1;
        tick();
        tick();
        chk("idle_redir_pc", dec_pc, 32'h0000_0010);
        chk("idle_redir_instr", dec_instr, 32'h1000_0004);

        // wrap past the last ROM word
        do_reset();
        fetch_en  = 1'b1;
        dec_ready = 1'b1;
        tick();
        redirect(32'h0000_0078);
        tick();
        chk("wrap_78", dec_pc, 32'h0000_0078);
        chk("wrap_78_instr", dec_instr, 32'h1000_001E);
        tick();
        chk("wrap_7c", dec_pc, 32'h0000_007C);
        chk("wrap_addr0", {27'b0, imem_addr}, 32'h0);
        tick();
        chk("wrap_80", dec_pc, 32'h0000_0080);
        chk("wrap_80_instr", dec_instr, 32'h0000_0193);

        // reset mid-stream with a full queue
        do_reset();
        fetch_en = 1'b1;
        tick();
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_valid", {31'b0, dec_valid}, 32'h0);
        chk("midrst_instr", dec_instr, 32'h0000_0013);
        chk("midrst_addr", {27'b0, imem_addr}, 32'h0);
        rst       = 1'b1;
        dec_ready = 1'b1;
        tick();
        tick();
        chk("midrst_restart_pc", dec_pc, 32'h0);
        chk("midrst_restart_instr", dec_instr, 32'h0000_0193);

        // misaligned redirect
        do_reset();
        fetch_en  = 1'b1;
        dec_ready = 1'b1;
        tick();
        redirect(32'h0000_0006);
        chk("mis_n1_valid", {31'b0, dec_valid}, 32'h0);
        tick();
`ifdef IFETCH_MISALIGN_CHK_EN
        chk("mis_err", {31'b0, fetch_err}, 32'h1);
        chk("mis_valid", {31'b0, dec_valid}, 32'h0);
        redirect(32'h0000_0000);
        tick();
        tick();
        chk("mis_ignored_valid", {31'b0, dec_valid}, 32'h0);
        chk("mis_ignored_err", {31'b0, fetch_err}, 32'h1);
        chk("mis_ignored_addr", {27'b0, imem_addr}, 32'h1);
`else
        chk("mis_masked_valid", {31'b0, dec_valid}, 32'h1);
        chk("mis_masked_pc", dec_pc, 32'h0000_0004);
        chk("mis_masked_instr", dec_instr, 32'h0010_0213);
        chk("mis_no_err", {31'b0, fetch_err}, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
